// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package hc595_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/hc595_chain_ctrl_if.sv
// Word handshake between a display front end and the 595 chain driver.
interface hc595_chain_ctrl_if #(
  parameter int unsigned CHAIN_BITS = 14
);

  logic [CHAIN_BITS-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output busy
  );

endinterface

// File: rtl/hc595_tick_gen.sv
// Half-period divider for shcp: tick on the last sys_clk cycle of each half, phase = shcp level.
module hc595_tick_gen
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick,
  output logic phase
);

  localparam int unsigned DivW = cnt_width(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            phase_q, phase_d;

  assign tick  = (div_q == DivMax);
  assign phase = phase_q;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (clr) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a cascaded 74HC595 chain: shift a word out on ds/shcp, latch with stcp.
// Optional HC595_AUTO_REFRESH_EN re-sends the last word after REFRESH_CYCLES idle cycles.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int unsigned CHAIN_BITS     = 14,
  parameter int unsigned CLK_DIV        = 2,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  hc595_chain_ctrl_if.slave  bus,
  output logic               ds,
  output logic               shcp,
  output logic               stcp,
  output logic               oe
);

  localparam int unsigned BitW = cnt_width(CHAIN_BITS);
  localparam logic [BitW-1:0] LastBit = BitW'(CHAIN_BITS - 1);

  state_e                state_q, state_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [CHAIN_BITS-1:0] shreg_q, shreg_d;
  logic                  stcp_q, stcp_d;
  logic                  oe_q, oe_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  tick, phase, tick_clr;
  logic                  accept, start;
  logic [CHAIN_BITS-1:0] start_word;

  assign accept = (state_q == StIdle) && ready_q && bus.din_valid;

`ifdef HC595_AUTO_REFRESH_EN
  localparam int unsigned RefW = cnt_width(REFRESH_CYCLES);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);

  logic [RefW-1:0]       ref_q, ref_d;
  logic [CHAIN_BITS-1:0] word_q, word_d;
  logic                  have_q, have_d;
  logic                  refresh;

  assign refresh    = (state_q == StIdle) && have_q && (ref_q == RefLast);
  assign start      = accept || refresh;
  // A fresh word always wins over a refresh expiring in the same cycle.
  assign start_word = accept ? bus.din : word_q;

  always_comb begin
    word_d = accept ? bus.din : word_q;
    have_d = have_q || accept;
    if (start || (state_q != StIdle) || !have_q) begin
      ref_d = '0;
    end else begin
      ref_d = ref_q + RefW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ref_q  <= '0;
      word_q <= '0;
      have_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      word_q <= word_d;
      have_q <= have_d;
    end
  end
`else
  logic unused_refresh;

  assign unused_refresh = ^REFRESH_CYCLES;
  assign start          = accept;
  assign start_word     = bus.din;
`endif

  hc595_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (tick_clr),
    .tick    (tick),
    .phase   (phase)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    oe_d     = oe_q;
    tick_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_clr = 1'b1;
        if (start) begin
          state_d = StShift;
          bit_d   = '0;
          shreg_d = start_word;
        end
      end
      StShift: begin
        // A bit ends on the tick that closes its shcp-high half.
        if (tick && phase) begin
          if (bit_q == LastBit) begin
            state_d = StLatch;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
      end
      StLatch: begin
        if (tick) begin
          state_d  = StIdle;
          oe_d     = 1'b0;
          tick_clr = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    stcp_d  = (state_d == StLatch);
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      bit_q   <= '0;
      shreg_q <= '0;
      stcp_q  <= 1'b0;
      oe_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      stcp_q  <= stcp_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // The outgoing bit sits at the shift end, so ds holds the last bit once shifting stops.
  assign ds            = MSB_FIRST ? shreg_q[CHAIN_BITS-1] : shreg_q[0];
  assign shcp          = phase;
  assign stcp          = stcp_q;
  assign oe            = oe_q;
  assign bus.din_ready = ready_q;
  assign bus.busy      = busy_q;

endmodule
